// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that reuses one full-adder slice for WIDTH cycles.
// Operands are captured on start and processed LSB-first, with the carry kept in a
// register between cycles. The result and a one-cycle done strobe are registered.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed Overflow output.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Overflow
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             s;
   logic             c_next;

`ifdef SERIAL_ADDER_OVF_EN
   // Carry into the MSB position, latched during the final SHIFT cycle.
   logic             c_msb;
`endif

   // The single full-adder slice operating on the current LSBs.
   assign s      = a_sr[0] ^ b_sr[0] ^ c;
   assign c_next = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & c);

   // Control FSM plus datapath registers; results change only in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Sum    <= '0;
         Carry  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         c_msb    <= 1'b0;
         Overflow <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  c     <= Cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sum_sr <= {s, sum_sr[WIDTH-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               c      <= c_next;
               if (cnt == LAST) begin
                  // Counter stops at WIDTH-1 rather than wrapping.
`ifdef SERIAL_ADDER_OVF_EN
                  c_msb <= c;
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               Sum   <= sum_sr;
               Carry <= c;
`ifdef SERIAL_ADDER_OVF_EN
               Overflow <= c_msb ^ c;
`endif
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         busy;
   logic         done;
   logic [W-1:0] Sum;
   logic         Carry;
`ifdef SERIAL_ADDER_OVF_EN
   logic         Overflow;
`endif

   int checks = 0;
   int passed = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Carry (Carry)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .Overflow (Overflow)
`endif
   );

   always #5 clk = ~clk;

   // Pulse start for one edge (E0), then wait up to 20 edges for done.
   // lat is the edge index after E0 at which done became visible (0 = timeout).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, output int lat, output int busy_cycles);
      @(negedge clk);
      A = a; B = b; Cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_cycles = busy ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (Sum !== 8'h00 || Carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle%0d: Sum=%h Carry=%b busy=%b done=%b, want 00 0 0 0",
                     i, Sum, Carry, busy, done);
         else passed++;
      end
   endtask

   task automatic test_basic();
      int lat, bc;
      run_op(8'h0F, 8'h01, 1'b0, lat, bc);
      checks++;
      if (lat !== 9) $display("FAIL basic_latency: got %0d, want 9", lat);
      else passed++;
      checks++;
      if (bc !== 9) $display("FAIL basic_busy_cycles: got %0d, want 9", bc);
      else passed++;
      checks++;
      if (Sum !== 8'h10 || Carry !== 1'b0)
         $display("FAIL basic_result: Sum=%h Carry=%b, want 10 0", Sum, Carry);
      else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b, want 0", busy);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) $display("FAIL basic_done_one_cycle: got %b, want 0", done);
      else passed++;
      // Result must hold while the next operation is in progress.
      @(negedge clk);
      A = 8'hFF; B = 8'h01; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (Sum !== 8'h10 || Carry !== 1'b0 || busy !== 1'b1)
         $display("FAIL basic_hold: Sum=%h Carry=%b busy=%b, want 10 0 1", Sum, Carry, busy);
      else passed++;
      for (int i = 0; i < 10 && !done; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || Sum !== 8'h00 || Carry !== 1'b1)
         $display("FAIL carry_wrap: done=%b Sum=%h Carry=%b, want 1 00 1", done, Sum, Carry);
      else passed++;
   endtask

   task automatic test_cin();
      int lat, bc;
      run_op(8'h00, 8'h00, 1'b1, lat, bc);
      checks++;
      if (lat !== 9 || Sum !== 8'h01 || Carry !== 1'b0)
         $display("FAIL cin_only: lat=%0d Sum=%h Carry=%b, want 9 01 0", lat, Sum, Carry);
      else passed++;
      run_op(8'hA5, 8'h3C, 1'b1, lat, bc);
      checks++;
      if (lat !== 9 || Sum !== 8'hE2 || Carry !== 1'b0)
         $display("FAIL mixed: lat=%0d Sum=%h Carry=%b, want 9 e2 0", lat, Sum, Carry);
      else passed++;
      run_op(8'hFF, 8'hFF, 1'b1, lat, bc);
      checks++;
      if (lat !== 9 || Sum !== 8'hFF || Carry !== 1'b1)
         $display("FAIL all_ones: lat=%0d Sum=%h Carry=%b, want 9 ff 1", lat, Sum, Carry);
      else passed++;
   endtask

   task automatic test_start_while_busy();
      int ndone;
      @(negedge clk);
      A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 4) begin
            A = 8'hFF; B = 8'hFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) ndone++;
      end
      checks++;
      if (ndone !== 1) $display("FAIL busy_start_ignored: done pulses=%0d, want 1", ndone);
      else passed++;
      checks++;
      if (Sum !== 8'h46 || Carry !== 1'b0)
         $display("FAIL busy_start_result: Sum=%h Carry=%b, want 46 0", Sum, Carry);
      else passed++;
   endtask

   task automatic test_reset_mid_op();
      int ndone, lat, bc;
      @(negedge clk);
      A = 8'h55; B = 8'h66; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (Sum !== 8'h00 || Carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL rst_mid_op: Sum=%h Carry=%b busy=%b done=%b, want 00 0 0 0",
                  Sum, Carry, busy, done);
      else passed++;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone !== 0) $display("FAIL rst_abandon: active cycles=%0d, want 0", ndone);
      else passed++;
      run_op(8'h03, 8'h04, 1'b0, lat, bc);
      checks++;
      if (lat !== 9 || Sum !== 8'h07 || Carry !== 1'b0)
         $display("FAIL rst_recover: lat=%0d Sum=%h Carry=%b, want 9 07 0", lat, Sum, Carry);
      else passed++;
      // rst and start together: rst wins, nothing starts.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; A = 8'h01; B = 8'h01;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || Sum !== 8'h00)
         $display("FAIL rst_beats_start: busy=%b Sum=%h, want 0 00", busy, Sum);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int d1, d2;
      logic [W-1:0] s1;
      @(negedge clk);
      A = 8'h01; B = 8'h02; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      A = 8'h05; B = 8'h06;
      d1 = 0; d2 = 0; s1 = '0;
      for (int i = 1; i <= 24; i++) begin
         @(posedge clk); #1;
         if (i == 10) start = 1'b0;
         if (done && d1 == 0) begin
            d1 = i; s1 = Sum;
         end else if (done && d2 == 0) begin
            d2 = i;
         end
      end
      checks++;
      if (d1 !== 9 || s1 !== 8'h03)
         $display("FAIL b2b_first: edge=%0d Sum=%h, want 9 03", d1, s1);
      else passed++;
      checks++;
      if (d2 !== 19 || Sum !== 8'h0B)
         $display("FAIL b2b_second: edge=%0d Sum=%h, want 19 0b", d2, Sum);
      else passed++;
   endtask

`ifdef SERIAL_ADDER_OVF_EN
   task automatic test_overflow();
      int lat, bc;
      run_op(8'h7F, 8'h01, 1'b0, lat, bc);
      checks++;
      if (Sum !== 8'h80 || Overflow !== 1'b1 || Carry !== 1'b0)
         $display("FAIL ovf_pos: Sum=%h Ovf=%b Carry=%b, want 80 1 0", Sum, Overflow, Carry);
      else passed++;
      run_op(8'hFF, 8'h01, 1'b0, lat, bc);
      checks++;
      if (Sum !== 8'h00 || Overflow !== 1'b0 || Carry !== 1'b1)
         $display("FAIL ovf_none: Sum=%h Ovf=%b Carry=%b, want 00 0 1", Sum, Overflow, Carry);
      else passed++;
      run_op(8'h80, 8'h80, 1'b0, lat, bc);
      checks++;
      if (Sum !== 8'h00 || Overflow !== 1'b1 || Carry !== 1'b1)
         $display("FAIL ovf_neg: Sum=%h Ovf=%b Carry=%b, want 00 1 1", Sum, Overflow, Carry);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_cin();
      test_start_while_busy();
      test_reset_mid_op();
      test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
      test_overflow();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder stage that drives one full-adder slice for `WIDTH` consecutive cycles instead of instantiating `WIDTH` slices in parallel. Operands are captured on a start request and processed LSB-first, with the carry held in a register between cycles. The final sum and carry-out are presented as a registered result with a one-cycle completion strobe. The block sits directly downstream of the single-bit full-adder cell and is the sequential wrapper that consumes its Sum/Carry outputs bit by bit.

## Interface
- `WIDTH`, default 8: operand and result width in bits; minimum 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to begin an addition; sampled only in IDLE.
- `A` input WIDTH: operand A; captured when `start` is accepted.
- `B` input WIDTH: operand B; captured when `start` is accepted.
- `Cin` input 1: carry-in; captured when `start` is accepted.
- `busy` output 1: high from the cycle after acceptance through the DONE cycle.
- `done` output 1: one-cycle strobe; `Sum`/`Carry` are valid from this cycle onward.
- `Sum` output WIDTH: registered result, (A + B + Cin) mod 2^WIDTH.
- `Carry` output 1: registered carry-out of the MSB.
- `Overflow` output 1: signed overflow flag; present only with `SERIAL_ADDER_OVF_EN` defined.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE: if `start`=1, load the shift registers with A and B, load the carry register with Cin, clear the bit counter, and go to SHIFT. `start` has no effect in any other state.
- SHIFT: each cycle the slice computes s = a0 ^ b0 ^ c and c' = a0&b0 | (a0^b0)&c.
  - s shifts into the MSB of the internal sum shift register.
  - The operand registers shift right by one.
  - The carry register takes c'.
  - The counter increments.
  - After the cycle with counter = WIDTH-1, go to DONE.
- DONE: copy the internal sum register to `Sum` and the carry register to `Carry`, assert `done` for this single cycle, then go to IDLE.
- `Sum`/`Carry` (and `Overflow`) change only on the DONE transition. They hold stable during a subsequent operation until its own DONE.
- The counter is $clog2(WIDTH) bits wide and does not wrap during an operation.
- Reset mid-operation: the operation is abandoned with no `done` pulse. All registers return to reset values.
- Reset values: `Sum`=0, `Carry`=0, `busy`=0, `done`=0, `Overflow`=0; internal registers all 0.

## Timing
- Start accepted at edge E0. SHIFT occupies edges E1..E_WIDTH; the DONE registers update at edge E(WIDTH+1).
- `done` and the new `Sum`/`Carry` are visible in the cycle after edge E(WIDTH+1).
- Total latency from accepting edge to `done` visible: WIDTH+1 cycles (9 for WIDTH=8).
- `busy`=1 for WIDTH+1 cycles per operation.
- Back-to-back: `start` held high through DONE is accepted on the first IDLE cycle after DONE. Throughput is one result per WIDTH+2 cycles.
- `start` asserted while `busy`=1 is dropped; it is not queued.
- `rst` and `start` asserted in the same cycle: `rst` wins.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - The `Overflow` port exists.
  - The block keeps the carry into the MSB position, captured during the last SHIFT cycle.
  - In DONE, `Overflow` is loaded with (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow.
  - `Overflow` holds with the same rules as `Sum`.
- `SERIAL_ADDER_OVF_EN` not defined: no `Overflow` port and no extra register; all other behaviour is identical.

## Test plan
- Reset, then idle 3 cycles -> `Sum`=0, `Carry`=0, `busy`=0, `done`=0 throughout.
- WIDTH=8, A=8'h0F, B=8'h01, Cin=0, start pulse -> `done` exactly 9 cycles later, `Sum`=8'h10, `Carry`=0; values held until the next DONE.
- A=8'hFF, B=8'h01, Cin=0 -> `Sum`=8'h00, `Carry`=1. Then A=8'h00, B=8'h00, Cin=1 -> `Sum`=8'h01, `Carry`=0.
- Start A=8'h12, B=8'h34; pulse start with A=8'hFF, B=8'hFF at cycle 4 -> single `done`, `Sum`=8'h46; second request ignored.
- Start an operation, assert `rst` at cycle 5 -> no `done`, all outputs 0 next cycle. A new start afterwards completes normally after 9 cycles.
- With `SERIAL_ADDER_OVF_EN`:
  - A=8'h7F, B=8'h01 -> `Sum`=8'h80, `Overflow`=1, `Carry`=0.
  - A=8'hFF, B=8'h01 -> `Overflow`=0, `Carry`=1.
